// File: rtl/mdu_pkg.sv
// Shared types and decode for the RV64M multiply/divide sequencer.
// The ALU_* values mirror the core's define.v encodings for the M-extension ops.
package mdu_pkg;

    localparam int N64 = 64;
    localparam int N32 = 32;

    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;
    localparam logic [4:0] ALU_MULW   = 5'd24;
    localparam logic [4:0] ALU_DIVW   = 5'd25;
    localparam logic [4:0] ALU_DIVUW  = 5'd26;
    localparam logic [4:0] ALU_REMW   = 5'd27;
    localparam logic [4:0] ALU_REMUW  = 5'd28;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} mdu_state_t;

    typedef struct packed {
        logic is_mul;
        logic is_div;
        logic is_rem;
        logic is_high;
        logic is_w;
        logic s1_signed;
        logic s2_signed;
    } op_class_t;

    // Non-M opcodes decode to all zeros, which the sequencer treats as "not mine".
    function automatic op_class_t decode_op(input logic [4:0] aluop);
        op_class_t c;
        c = '0;
        case (aluop)
            ALU_MUL:    begin c.is_mul = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_MULH:   begin c.is_mul = 1'b1; c.is_high = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_MULHSU: begin c.is_mul = 1'b1; c.is_high = 1'b1; c.s1_signed = 1'b1; end
            ALU_MULHU:  begin c.is_mul = 1'b1; c.is_high = 1'b1; end
            ALU_DIV:    begin c.is_div = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_DIVU:   begin c.is_div = 1'b1; end
            ALU_REM:    begin c.is_div = 1'b1; c.is_rem = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_REMU:   begin c.is_div = 1'b1; c.is_rem = 1'b1; end
            ALU_MULW:   begin c.is_mul = 1'b1; c.is_w = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_DIVW:   begin c.is_div = 1'b1; c.is_w = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_DIVUW:  begin c.is_div = 1'b1; c.is_w = 1'b1; end
            ALU_REMW:   begin c.is_div = 1'b1; c.is_rem = 1'b1; c.is_w = 1'b1; c.s1_signed = 1'b1; c.s2_signed = 1'b1; end
            ALU_REMUW:  begin c.is_div = 1'b1; c.is_rem = 1'b1; c.is_w = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [63:0] w_fix(input logic [63:0] r, input logic is_w);
        return is_w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module mdu_div_step (
    input  logic [64:0] rem_i,
    input  logic        dvd_msb_i,
    input  logic [63:0] dvs_i,
    output logic [64:0] rem_o,
    output logic        q_bit_o
);

    logic [65:0] diff;

    always_comb begin
        // rem_i[64] is always zero between steps, so the trial difference fits in 66 bits.
        diff    = {rem_i, dvd_msb_i} - {2'b00, dvs_i};
        q_bit_o = ~diff[65];
        rem_o   = q_bit_o ? diff[64:0] : {rem_i[63:0], dvd_msb_i};
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV64M sequencer: iterative shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN to compute all MUL* ops with a single-cycle product in PREP.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [4:0]      aluop_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_t state_q;
    op_class_t  op_q, dec_op;
    logic [6:0]  cnt_q, last_cnt;
    logic [63:0] op1_q, op2_q, dvd_q, result_q;
    logic [64:0] rem_q, rem_d;
    logic        neg_q, neg_rem_q, busy_q, done_q;
    logic        is_m_op, accept, q_bit;
    logic        sign_a, sign_b, div_zero, div_ovf;
    logic [63:0] a_ext, b_ext, abs_a, abs_b, min_neg, special_res;
    logic [63:0] dvd_d, quo_fix, rem_fix, fix_res;
`ifdef MDU_FAST_MUL_EN
    logic [127:0] fast_a, fast_b, fast_prod;
    logic [63:0]  fast_res;
`else
    logic [127:0] acc_q, acc_d, prod, prod_s;
    logic [64:0]  acc_sum;
    logic [63:0]  mul_res;
`endif

    assign dec_op  = decode_op(aluop_i);
    assign is_m_op = dec_op.is_mul | dec_op.is_div;
    assign accept  = start_i & (state_q == IDLE) & is_m_op & ~kill_i;
    assign stall_o = (start_i & (state_q == IDLE) & is_m_op) | busy_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

    // Operand conditioning in PREP: W extension, magnitudes and the special divide cases.
    always_comb begin
        a_ext = op_q.is_w ? {{32{op_q.s1_signed & op1_q[31]}}, op1_q[31:0]} : op1_q;
        b_ext = op_q.is_w ? {{32{op_q.s2_signed & op2_q[31]}}, op2_q[31:0]} : op2_q;
        sign_a = op_q.s1_signed & a_ext[63];
        sign_b = op_q.s2_signed & b_ext[63];
        abs_a  = sign_a ? (64'd0 - a_ext) : a_ext;
        abs_b  = sign_b ? (64'd0 - b_ext) : b_ext;
        min_neg  = op_q.is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = op_q.is_div & (b_ext == 64'd0);
        div_ovf  = op_q.is_div & op_q.s1_signed & (a_ext == min_neg) & (&b_ext);
        if (div_zero) special_res = op_q.is_rem ? a_ext : {64{1'b1}};
        else          special_res = op_q.is_rem ? 64'd0 : a_ext;
        last_cnt = op_q.is_w ? 7'(N32 - 1) : 7'(N64 - 1);
    end

    mdu_div_step u_div_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[63]),
        .dvs_i     (op2_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit)
    );
    assign dvd_d = {dvd_q[62:0], q_bit};

`ifdef MDU_FAST_MUL_EN
    always_comb begin
        fast_a    = {{64{sign_a}}, a_ext};
        fast_b    = {{64{sign_b}}, b_ext};
        fast_prod = fast_a * fast_b;
        fast_res  = w_fix(op_q.is_high ? fast_prod[127:64] : fast_prod[63:0], op_q.is_w);
    end
`else
    // Multiplier bits retire from acc_q[0]; the partial product grows in the high half.
    always_comb begin
        acc_sum = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, op1_q} : 65'd0);
        acc_d   = {acc_sum, acc_q[63:1]};
        prod    = op_q.is_w ? {32'd0, acc_q[127:32]} : acc_q;
        prod_s  = neg_q ? (128'd0 - prod) : prod;
        mul_res = op_q.is_high ? prod_s[127:64] : prod_s[63:0];
    end
`endif

    always_comb begin
        quo_fix = neg_q ? (64'd0 - dvd_q) : dvd_q;
        rem_fix = neg_rem_q ? (64'd0 - rem_q[63:0]) : rem_q[63:0];
`ifdef MDU_FAST_MUL_EN
        fix_res = w_fix(op_q.is_rem ? rem_fix : quo_fix, op_q.is_w);
`else
        fix_res = w_fix(op_q.is_mul ? mul_res : (op_q.is_rem ? rem_fix : quo_fix), op_q.is_w);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;  op_q <= '0;  cnt_q <= '0;
            op1_q <= '0;  op2_q <= '0;  dvd_q <= '0;  rem_q <= '0;
            neg_q <= 1'b0;  neg_rem_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;  result_q <= '0;
`ifndef MDU_FAST_MUL_EN
            acc_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    op_q <= dec_op;  op1_q <= operand1_i;  op2_q <= operand2_i;
                    state_q <= PREP;  busy_q <= 1'b1;
                end
                PREP: begin
                    if (kill_i) begin
                        state_q <= IDLE;  busy_q <= 1'b0;
                    end else if (div_zero | div_ovf) begin
                        result_q <= w_fix(special_res, op_q.is_w);
                        state_q <= DONE;  done_q <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                    end else if (op_q.is_mul) begin
                        result_q <= fast_res;
                        state_q <= DONE;  done_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= '0;
                        neg_q <= sign_a ^ sign_b;  neg_rem_q <= sign_a;
                        op1_q <= abs_a;  op2_q <= abs_b;  rem_q <= '0;
                        // W divides consume only 32 dividend bits, so left-align them.
                        dvd_q <= op_q.is_w ? {abs_a[31:0], 32'd0} : abs_a;
`ifndef MDU_FAST_MUL_EN
                        acc_q <= {64'd0, op_q.is_w ? {32'd0, abs_b[31:0]} : abs_b};
`endif
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state_q <= IDLE;  busy_q <= 1'b0;
                    end else begin
`ifndef MDU_FAST_MUL_EN
                        if (op_q.is_mul) acc_q <= acc_d;
`endif
                        if (op_q.is_div) begin
                            rem_q <= rem_d;  dvd_q <= dvd_d;
                        end
                        if (cnt_q == last_cnt) state_q <= FIXUP;
                        else                   cnt_q <= cnt_q + 7'd1;
                    end
                end
                FIXUP: begin
                    if (kill_i) begin
                        state_q <= IDLE;  busy_q <= 1'b0;
                    end else begin
                        result_q <= fix_res;
                        state_q <= DONE;  done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;  busy_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;  busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
